// File: rtl/control_sequencer.sv
// Microcoded control unit for the 8-bit CPU: a T-state step counter plus an opcode
// decoder that drives the active-low datapath strobes, with a sticky halt.
//
// state   | meaning
// T0      | fetch: PC -> MAR
// T1      | fetch: RAM -> IR, PC increment
// T2..T4  | execute, decoded from opcode and flags
// T5..T7  | idle padding when STEPS > 5
// halted  | step frozen at T2, only o_halt asserted
module control_sequencer #(
   parameter int STEPS = 5
) (
   input  logic       i_clk,
   input  logic       i_rstn,
   input  logic [3:0] i_opcode,
   input  logic       i_carry,
   input  logic       i_zero,
   output logic       o_pc_cntn,
   output logic       o_pc_den,
   output logic       o_pc_din,
   output logic       o_mar_inn,
   output logic       o_ram_outn,
   output logic       o_ram_inn,
   output logic       o_ir_inn,
   output logic       o_ir_outn,
   output logic       o_a_inn,
   output logic       o_a_outn,
   output logic       o_b_inn,
   output logic       o_alu_outn,
   output logic       o_out_inn,
   output logic       o_alu_sub,
   output logic       o_flags_in,
   output logic       o_halt,
   output logic [2:0] o_tstate
);

   localparam logic [2:0] T0   = 3'd0;
   localparam logic [2:0] T1   = 3'd1;
   localparam logic [2:0] T2   = 3'd2;
   localparam logic [2:0] T3   = 3'd3;
   localparam logic [2:0] T4   = 3'd4;
   localparam logic [2:0] LAST = 3'(STEPS - 1);

   localparam logic [3:0] OP_LDA = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0011;
   localparam logic [3:0] OP_STA = 4'b0100;
   localparam logic [3:0] OP_LDI = 4'b0101;
   localparam logic [3:0] OP_JMP = 4'b0110;
   localparam logic [3:0] OP_JC  = 4'b0111;
   localparam logic [3:0] OP_JZ  = 4'b1000;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   logic [2:0] step;
   logic       halted;

   logic pc_cnt, pc_de, pc_di, mar_in, ram_out, ram_in, ir_in, ir_out;
   logic a_in, a_out, b_in, alu_out, out_in, alu_sub, flags_in, halt_req;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         step   <= T0;
         halted <= 1'b0;
      end else if (!halted) begin
         if (step == T2 && i_opcode == OP_HLT)
            halted <= 1'b1;
         else if (step == LAST)
            step <= T0;
         else
            step <= step + 3'd1;
      end
   end

   // Strobes are gated by i_rstn so they go inactive the instant reset asserts.
   always_comb begin
      pc_cnt   = 1'b0;
      pc_de    = 1'b0;
      pc_di    = 1'b0;
      mar_in   = 1'b0;
      ram_out  = 1'b0;
      ram_in   = 1'b0;
      ir_in    = 1'b0;
      ir_out   = 1'b0;
      a_in     = 1'b0;
      a_out    = 1'b0;
      b_in     = 1'b0;
      alu_out  = 1'b0;
      out_in   = 1'b0;
      alu_sub  = 1'b0;
      flags_in = 1'b0;
      halt_req = i_rstn & halted;
      if (i_rstn && !halted) begin
         case (step)
            T0: begin
               pc_de  = 1'b1;
               mar_in = 1'b1;
            end
            T1: begin
               ram_out = 1'b1;
               ir_in   = 1'b1;
               pc_cnt  = 1'b1;
            end
            T2: begin
               case (i_opcode)
                  OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                     ir_out = 1'b1;
                     mar_in = 1'b1;
                  end
                  OP_LDI: begin
                     ir_out = 1'b1;
                     a_in   = 1'b1;
                  end
                  OP_JMP: begin
                     ir_out = 1'b1;
                     pc_di  = 1'b1;
                  end
                  OP_JC: begin
                     ir_out = i_carry;
                     pc_di  = i_carry;
                  end
                  OP_JZ: begin
                     ir_out = i_zero;
                     pc_di  = i_zero;
                  end
                  OP_OUT: begin
                     a_out  = 1'b1;
                     out_in = 1'b1;
                  end
                  OP_HLT: halt_req = 1'b1;
                  default: ;
               endcase
            end
            T3: begin
               case (i_opcode)
                  OP_LDA: begin
                     ram_out = 1'b1;
                     a_in    = 1'b1;
                  end
                  OP_ADD, OP_SUB: begin
                     ram_out = 1'b1;
                     b_in    = 1'b1;
                  end
                  OP_STA: begin
                     a_out  = 1'b1;
                     ram_in = 1'b1;
                  end
                  default: ;
               endcase
            end
            T4: begin
               if (i_opcode == OP_ADD || i_opcode == OP_SUB) begin
                  alu_out  = 1'b1;
                  a_in     = 1'b1;
                  flags_in = 1'b1;
                  alu_sub  = (i_opcode == OP_SUB);
               end
            end
            default: ;
         endcase
      end
   end

   assign o_pc_cntn  = ~pc_cnt;
   assign o_pc_den   = ~pc_de;
   assign o_pc_din   = ~pc_di;
   assign o_mar_inn  = ~mar_in;
   assign o_ram_outn = ~ram_out;
   assign o_ram_inn  = ~ram_in;
   assign o_ir_inn   = ~ir_in;
   assign o_ir_outn  = ~ir_out;
   assign o_a_inn    = ~a_in;
   assign o_a_outn   = ~a_out;
   assign o_b_inn    = ~b_in;
   assign o_alu_outn = ~alu_out;
   assign o_out_inn  = ~out_in;
   assign o_alu_sub  = alu_sub;
   assign o_flags_in = flags_in;
   assign o_halt     = halt_req;
   assign o_tstate   = step;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: an instruction-table reference model indexed by
// opcode and step, with directed scenarios and a long randomized run.
module tb_control_sequencer;
   localparam int STEPS = 5;

   localparam int PC_CNT = 15, PC_DE = 14, PC_DI = 13, MAR_IN = 12, RAM_OUT = 11;
   localparam int RAM_IN = 10, IR_IN = 9, IR_OUT = 8, A_IN = 7, A_OUT = 6, B_IN = 5;
   localparam int ALU_OUT = 4, OUT_IN = 3, ALU_SUB = 2, FLAGS_IN = 1, HALT = 0;

   logic       i_clk = 1'b0;
   logic       i_rstn;
   logic [3:0] i_opcode;
   logic       i_carry, i_zero;
   logic o_pc_cntn, o_pc_den, o_pc_din, o_mar_inn, o_ram_outn, o_ram_inn, o_ir_inn;
   logic o_ir_outn, o_a_inn, o_a_outn, o_b_inn, o_alu_outn, o_out_inn;
   logic o_alu_sub, o_flags_in, o_halt;
   logic [2:0] o_tstate;

   int compared = 0;
   int mismatched = 0;

   logic [15:0] ucode [16][8];
   int  m_step;
   bit  m_halted;

   control_sequencer #(.STEPS(STEPS)) dut (
      .i_clk(i_clk), .i_rstn(i_rstn), .i_opcode(i_opcode), .i_carry(i_carry),
      .i_zero(i_zero), .o_pc_cntn(o_pc_cntn), .o_pc_den(o_pc_den), .o_pc_din(o_pc_din),
      .o_mar_inn(o_mar_inn), .o_ram_outn(o_ram_outn), .o_ram_inn(o_ram_inn),
      .o_ir_inn(o_ir_inn), .o_ir_outn(o_ir_outn), .o_a_inn(o_a_inn), .o_a_outn(o_a_outn),
      .o_b_inn(o_b_inn), .o_alu_outn(o_alu_outn), .o_out_inn(o_out_inn),
      .o_alu_sub(o_alu_sub), .o_flags_in(o_flags_in), .o_halt(o_halt), .o_tstate(o_tstate)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [15:0] bm(int b);
      logic [15:0] one;
      one = 16'd1;
      return one << b;
   endfunction

   // Instruction table: what each opcode does in each step, independent of flags.
   task automatic build_ucode();
      for (int op = 0; op < 16; op++) begin
         for (int s = 0; s < 8; s++) ucode[op][s] = '0;
         ucode[op][0] = bm(PC_DE) | bm(MAR_IN);
         ucode[op][1] = bm(RAM_OUT) | bm(IR_IN) | bm(PC_CNT);
      end
      ucode[1][2] = bm(IR_OUT) | bm(MAR_IN);
      ucode[1][3] = bm(RAM_OUT) | bm(A_IN);
      for (int op = 2; op <= 3; op++) begin
         ucode[op][2] = bm(IR_OUT) | bm(MAR_IN);
         ucode[op][3] = bm(RAM_OUT) | bm(B_IN);
         ucode[op][4] = bm(ALU_OUT) | bm(A_IN) | bm(FLAGS_IN) | ((op == 3) ? bm(ALU_SUB) : 16'd0);
      end
      ucode[4][2]  = bm(IR_OUT) | bm(MAR_IN);
      ucode[4][3]  = bm(A_OUT) | bm(RAM_IN);
      ucode[5][2]  = bm(IR_OUT) | bm(A_IN);
      ucode[6][2]  = bm(IR_OUT) | bm(PC_DI);
      ucode[7][2]  = bm(IR_OUT) | bm(PC_DI);
      ucode[8][2]  = bm(IR_OUT) | bm(PC_DI);
      ucode[14][2] = bm(A_OUT) | bm(OUT_IN);
      ucode[15][2] = bm(HALT);
   endtask

   function automatic logic [15:0] expected();
      if (!i_rstn) return '0;
      if (m_halted) return bm(HALT);
      if (m_step == 2 && i_opcode == 4'd7 && !i_carry) return '0;
      if (m_step == 2 && i_opcode == 4'd8 && !i_zero) return '0;
      return ucode[i_opcode][m_step];
   endfunction

   function automatic logic [15:0] observed();
      return {~o_pc_cntn, ~o_pc_den, ~o_pc_din, ~o_mar_inn, ~o_ram_outn, ~o_ram_inn,
              ~o_ir_inn, ~o_ir_outn, ~o_a_inn, ~o_a_outn, ~o_b_inn, ~o_alu_outn,
              ~o_out_inn, o_alu_sub, o_flags_in, o_halt};
   endfunction

   // One clock: the model moves with the same inputs the DUT sees at the edge.
   task automatic advance();
      @(posedge i_clk);
      if (!i_rstn) begin
         m_step = 0;
         m_halted = 0;
      end else if (!m_halted) begin
         if (m_step == 2 && i_opcode == 4'hF) m_halted = 1;
         else m_step = (m_step + 1) % STEPS;
      end
      #1;
   endtask

   task automatic release_reset();
      advance();
      i_rstn = 1'b1;
   endtask

   task automatic test_reset();
      i_rstn = 1'b0;
      i_opcode = 4'($urandom_range(0, 15));
      i_carry = 1'b1;
      i_zero = 1'b1;
      m_step = 0;
      m_halted = 0;
      repeat (2) advance();
      @(negedge i_clk);
      compared++;
      if (observed() !== 16'd0) begin
         mismatched++;
         $display("FAIL reset_strobes: got %h want 0000", observed());
      end
      compared++;
      if (o_tstate !== 3'd0) begin
         mismatched++;
         $display("FAIL reset_tstate: got %0d want 0", o_tstate);
      end
      release_reset();
      i_opcode = 4'd0;
      i_carry = 1'b0;
      i_zero = 1'b0;
   endtask

   task automatic test_nop_cycle();
      for (int n = 0; n < 2 * STEPS; n++) begin
         @(negedge i_clk);
         compared++;
         if (o_tstate !== 3'(m_step)) begin
            mismatched++;
            $display("FAIL nop_tstate: got %0d want %0d", o_tstate, m_step);
         end
         compared++;
         if (observed() !== expected()) begin
            mismatched++;
            $display("FAIL nop_strobes t%0d: got %h want %h", m_step, observed(), expected());
         end
         advance();
      end
   endtask

   task automatic test_add_sub();
      for (int k = 0; k < 2; k++) begin
         i_opcode = (k == 0) ? 4'd2 : 4'd3;
         for (int n = 0; n < STEPS; n++) begin
            @(negedge i_clk);
            compared++;
            if (observed() !== expected() || o_tstate !== 3'(m_step)) begin
               mismatched++;
               $display("FAIL alu_op%0d t%0d: got %h/%0d want %h/%0d", i_opcode, m_step,
                        observed(), o_tstate, expected(), m_step);
            end
            advance();
         end
      end
   endtask

   task automatic test_cond_jumps();
      for (int k = 0; k < 4; k++) begin
         i_opcode = (k < 2) ? 4'd7 : 4'd8;
         i_carry = (k == 0);
         i_zero = (k == 2);
         for (int n = 0; n < STEPS; n++) begin
            @(negedge i_clk);
            compared++;
            if (observed() !== expected()) begin
               mismatched++;
               $display("FAIL jump_op%0d c%0d z%0d t%0d: got %h want %h", i_opcode, i_carry,
                        i_zero, m_step, observed(), expected());
            end
            advance();
         end
      end
      i_carry = 1'b0;
      i_zero = 1'b0;
   endtask

   task automatic test_undefined();
      for (int op = 9; op <= 13; op++) begin
         i_opcode = 4'(op);
         i_carry = 1'($urandom);
         i_zero = 1'($urandom);
         for (int n = 0; n < STEPS; n++) begin
            @(negedge i_clk);
            compared++;
            if (observed() !== expected()) begin
               mismatched++;
               $display("FAIL undef_op%0d t%0d: got %h want %h", op, m_step, observed(), expected());
            end
            advance();
         end
      end
   endtask

   task automatic test_halt();
      i_opcode = 4'hF;
      for (int n = 0; n < 25; n++) begin
         @(negedge i_clk);
         compared++;
         if (observed() !== expected() || o_tstate !== 3'(m_step)) begin
            mismatched++;
            $display("FAIL halt_hold n%0d: got %h/%0d want %h/%0d", n, observed(), o_tstate,
                     expected(), m_step);
         end
         advance();
      end
      compared++;
      if (!m_halted || o_tstate !== 3'd2 || o_halt !== 1'b1) begin
         mismatched++;
         $display("FAIL halt_frozen: got tstate %0d halt %0d want 2 1", o_tstate, o_halt);
      end
      @(negedge i_clk);
      #2 i_rstn = 1'b0;
      m_step = 0;
      m_halted = 0;
      #1;
      compared++;
      if (o_halt !== 1'b0 || observed() !== 16'd0 || o_tstate !== 3'd0) begin
         mismatched++;
         $display("FAIL halt_async_clear: got %h/%0d want 0000/0", observed(), o_tstate);
      end
      release_reset();
      i_opcode = 4'd0;
      @(negedge i_clk);
      compared++;
      if (o_tstate !== 3'd0 || observed() !== expected()) begin
         mismatched++;
         $display("FAIL halt_restart: got %h/%0d want %h/0", observed(), o_tstate, expected());
      end
      advance();
   endtask

   task automatic test_reset_mid_instr();
      i_opcode = 4'd1;
      for (int k = 0; k < 2 * STEPS && m_step != 3; k++) advance();
      @(negedge i_clk);
      compared++;
      if (o_tstate !== 3'd3 || observed() !== expected()) begin
         mismatched++;
         $display("FAIL lda_t3: got %h/%0d want %h/3", observed(), o_tstate, expected());
      end
      #2 i_rstn = 1'b0;
      m_step = 0;
      m_halted = 0;
      #1;
      compared++;
      if (observed() !== 16'd0 || o_tstate !== 3'd0) begin
         mismatched++;
         $display("FAIL mid_reset_async: got %h/%0d want 0000/0", observed(), o_tstate);
      end
      advance();
      release_reset();
      for (int n = 0; n < STEPS; n++) begin
         @(negedge i_clk);
         compared++;
         if (observed() !== expected() || o_tstate !== 3'(m_step)) begin
            mismatched++;
            $display("FAIL mid_reset_restart t%0d: got %h/%0d want %h/%0d", m_step, observed(),
                     o_tstate, expected(), m_step);
         end
         advance();
      end
   endtask

   task automatic test_random();
      int drivers;
      for (int n = 0; n < 10000; n++) begin
         i_opcode = 4'($urandom_range(0, 14));
         i_carry = 1'($urandom);
         i_zero = 1'($urandom);
         @(negedge i_clk);
         compared++;
         if (observed() !== expected() || o_tstate !== 3'(m_step)) begin
            mismatched++;
            if (mismatched < 20)
               $display("FAIL random_decode op%0d t%0d: got %h/%0d want %h/%0d", i_opcode,
                        m_step, observed(), o_tstate, expected(), m_step);
         end
         drivers = int'(!o_pc_den) + int'(!o_ram_outn) + int'(!o_ir_outn) + int'(!o_a_outn)
                 + int'(!o_alu_outn);
         compared++;
         if (drivers > 1 || (!o_pc_cntn && !o_pc_din)) begin
            mismatched++;
            if (mismatched < 20)
               $display("FAIL random_invariant: got %0d drivers cnt %0d din %0d want <=1 not both",
                        drivers, o_pc_cntn, o_pc_din);
         end
         advance();
      end
   endtask

   initial begin
      i_rstn = 1'b0;
      i_opcode = 4'd0;
      i_carry = 1'b0;
      i_zero = 1'b0;
      build_ucode();
      test_reset();
      test_nop_cycle();
      test_add_sub();
      test_cond_jumps();
      test_undefined();
      test_reset_mid_instr();
      test_halt();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
